// File: rtl/imm_gen_fifo.sv
// Buffered RISC-V immediate generator: I/S/B/U/J extraction into XLEN bits, DEPTH-entry FIFO output.
// Optional Zicsr CSR immediate (ImmSrc=101) is enabled by defining IMM_ZICSR_EN.
module imm_gen_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     In,
  input  logic [2:0]      ImmSrc,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] Imm_Ext,
  output logic            imm_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LW-1:0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  // Builds one FIFO entry {imm, err}; every legal format is sign-extended from bit 31.
  function automatic logic [XLEN:0] gen_entry(input logic [31:0] ins, input logic [2:0] sel);
    logic [31:0]     v;
    logic [XLEN-1:0] x;
    logic            err;
    v   = 32'h0000_0000;
    x   = {XLEN{1'b0}};
    err = 1'b0;
    case (sel)
      3'b000:  v = {{20{ins[31]}}, ins[31:20]};
      3'b001:  v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'b010:  v = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      3'b011:  v = {ins[31:12], 12'h000};
      3'b100:  v = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
`ifdef IMM_ZICSR_EN
      3'b101:  v = {27'h000_0000, ins[19:15]};
`endif
      default: err = 1'b1;
    endcase
    if (!err) begin
      x       = {XLEN{v[31]}};
      x[31:0] = v;
    end else begin
      x = {XLEN{1'b0}};
    end
    return {x, err};
  endfunction

  logic [XLEN:0]   mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic [XLEN:0]   entry_s;
  logic [XLEN:0]   head_s;
  logic            push_s;
  logic            pop_s;
  logic            in_ready_s;
  logic            out_valid_s;

  assign entry_s     = gen_entry(In, ImmSrc);
  assign head_s      = mem_r[rd_ptr_r];
  // No full-bypass: a same-cycle pop never lets a push into a full FIFO.
  assign in_ready_s  = rst && (level_r != FULL_LVL);
  assign out_valid_s = (level_r != {LW{1'b0}});
  assign push_s      = in_valid && in_ready_s;
  assign pop_s       = out_valid_s && out_ready;

  // Storage and pointer update; reset discards every stored entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(XLEN+1){1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= entry_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Occupancy counter: unchanged when push and pop coincide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      level_r <= {LW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Head presentation, forced to zero when the FIFO is empty.
  always_comb begin
    Imm_Ext = {XLEN{1'b0}};
    imm_err = 1'b0;
    if (out_valid_s) begin
      Imm_Ext = head_s[XLEN:1];
      imm_err = head_s[0];
    end else begin
      Imm_Ext = {XLEN{1'b0}};
      imm_err = 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign level     = level_r;

endmodule

// File: tb/tb_imm_gen_fifo.sv
// Directed self-checking bench for imm_gen_fifo (XLEN=32 and XLEN=64 instances, DEPTH=2).
module tb_imm_gen_fifo;

  logic        clk;
  logic        rst;
  logic [31:0] In;
  logic [2:0]  ImmSrc;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready, in_ready64;
  logic [31:0] Imm_Ext;
  logic [63:0] Imm_Ext64;
  logic        imm_err, imm_err64;
  logic        out_valid, out_valid64;
  logic [1:0]  level, level64;

  int n_tests = 0;
  int n_fail  = 0;

  imm_gen_fifo #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .In(In), .ImmSrc(ImmSrc), .in_valid(in_valid),
    .in_ready(in_ready), .Imm_Ext(Imm_Ext), .imm_err(imm_err),
    .out_valid(out_valid), .out_ready(out_ready), .level(level)
  );

  imm_gen_fifo #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .rst(rst), .In(In), .ImmSrc(ImmSrc), .in_valid(in_valid),
    .in_ready(in_ready64), .Imm_Ext(Imm_Ext64), .imm_err(imm_err64),
    .out_valid(out_valid64), .out_ready(out_ready), .level(level64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; In = 32'h0; ImmSrc = 3'b000; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", 64'(Imm_Ext), 64'd0);
    chk("rst_err", 64'(imm_err), 64'd0);
    chk("rst_in_ready_low", 64'(in_ready), 64'd0);
    rst = 1'b1; #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // I-type, one-cycle latency
    In = 32'hFFF00093; ImmSrc = 3'b000; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("i_valid", 64'(out_valid), 64'd1);
    chk("i_imm", 64'(Imm_Ext), 64'hFFFFFFFF);
    chk("i_err", 64'(imm_err), 64'd0);
    chk("i_level", 64'(level), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("empty_valid", 64'(out_valid), 64'd0);
    chk("empty_imm", 64'(Imm_Ext), 64'd0);
    tick();
    chk("empty_pop_level", 64'(level), 64'd0);

    // S then B back-to-back, simultaneous push/pop at level 1
    In = 32'hFE112E23; ImmSrc = 3'b001; in_valid = 1'b1;
    tick();
    chk("s_imm", 64'(Imm_Ext), 64'hFFFFFFFC);
    In = 32'hFE000EE3; ImmSrc = 3'b010;
    tick(); in_valid = 1'b0;
    chk("b_valid", 64'(out_valid), 64'd1);
    chk("b_imm", 64'(Imm_Ext), 64'hFFFFFFFC);
    chk("b_level", 64'(level), 64'd1);
    tick();
    chk("sb_drained", 64'(level), 64'd0);

    // U-type at both widths
    In = 32'h800000B7; ImmSrc = 3'b011; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("u_imm32", 64'(Imm_Ext), 64'h80000000);
    chk("u_imm64", Imm_Ext64, 64'hFFFFFFFF80000000);
    tick();

    // J-type negative
    In = 32'hFFDFF06F; ImmSrc = 3'b100; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("j_imm32", 64'(Imm_Ext), 64'hFFFFFFFC);
    chk("j_imm64", Imm_Ext64, 64'hFFFFFFFFFFFFFFFC);
    tick();

    // Back-pressure with DEPTH=2
    out_ready = 1'b0;
    In = 32'h00500093; ImmSrc = 3'b000; in_valid = 1'b1;
    tick();
    In = 32'h123450B7; ImmSrc = 3'b011;
    tick();
    chk("bp_level_full", 64'(level), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    In = 32'hFFF00093; ImmSrc = 3'b000;
    tick();
    chk("bp_held_level", 64'(level), 64'd2);
    chk("bp_head0", 64'(Imm_Ext), 64'h00000005);
    out_ready = 1'b1;
    tick();
    chk("bp_head1", 64'(Imm_Ext), 64'h12345000);
    chk("bp_level1", 64'(level), 64'd1);
    tick(); in_valid = 1'b0;
    chk("bp_head2", 64'(Imm_Ext), 64'hFFFFFFFF);
    chk("bp_level_pp", 64'(level), 64'd1);
    tick();
    chk("bp_drained", 64'(level), 64'd0);

    // Illegal select
    In = 32'hFFF00093; ImmSrc = 3'b111; in_valid = 1'b1; out_ready = 1'b0;
    tick(); in_valid = 1'b0;
    chk("ill_valid", 64'(out_valid), 64'd1);
    chk("ill_imm", 64'(Imm_Ext), 64'd0);
    chk("ill_err", 64'(imm_err), 64'd1);
    out_ready = 1'b1;
    tick();

    // Zicsr select, macro-dependent
    In = 32'h3400D073; ImmSrc = 3'b101; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
`ifdef IMM_ZICSR_EN
    chk("z_imm", 64'(Imm_Ext), 64'h00000001);
    chk("z_err", 64'(imm_err), 64'd0);
    chk("z_imm64", Imm_Ext64, 64'h1);
`else
    chk("z_imm", 64'(Imm_Ext), 64'd0);
    chk("z_err", 64'(imm_err), 64'd1);
    chk("z_err64", 64'(imm_err64), 64'd1);
`endif
    tick();

    // Reset mid-operation
    out_ready = 1'b0;
    In = 32'h00500093; ImmSrc = 3'b000; in_valid = 1'b1;
    tick(); tick(); in_valid = 1'b0;
    chk("mr_level_pre", 64'(level), 64'd2);
    rst = 1'b0;
    tick();
    chk("mr_level", 64'(level), 64'd0);
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_imm", 64'(Imm_Ext), 64'd0);
    rst = 1'b1; #1;
    chk("mr_in_ready", 64'(in_ready), 64'd1);
    In = 32'h0080006F; ImmSrc = 3'b100; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("mr_first_imm", 64'(Imm_Ext), 64'h00000008);
    chk("mr_first_level", 64'(level), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_fifo.md
# imm_gen_fifo

Parametrised, buffered immediate generator for the RISC-V datapath. It extracts and extends I/S/B/U/J immediates from a 32-bit instruction word into an XLEN-wide value, and flags illegal format selects. Results pass through a DEPTH-entry FIFO with valid/ready handshakes on both sides. It sits between fetch/decode and the execute stage of the pipelined core, replacing the combinational two-format sign extender.

## Interface
- XLEN, 32, output data width; legal values are 32 or 64.
- DEPTH, 2, number of FIFO entries; a power of two, at least 2.
- LW, $clog2(DEPTH)+1, width of the occupancy counter (derived, not overridden).

- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-low.
- In  input  32  instruction word.
- ImmSrc  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (macro-dependent), others illegal.
- in_valid  input  1  In and ImmSrc are valid this cycle.
- in_ready  output  1  block can accept an entry.
- Imm_Ext  output  XLEN  head-entry immediate.
- imm_err  output  1  head entry had an illegal ImmSrc.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer takes the head entry.
- level  output  LW  number of occupied entries.

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready. Both can occur in the same cycle.
- in_ready = (level != DEPTH), and is forced to 0 while rst is low. There is no full-bypass: a pop in the same cycle does not raise in_ready when full.
- Extension is computed at push time. Each entry stores {imm[XLEN-1:0], err}.
- Format rules (s = In[31]; every format is sign-extended from bit 31 to XLEN):
  - I: {s..., In[31:20]}.
  - S: {s..., In[31:25], In[11:7]}.
  - B: {s..., In[7], In[30:25], In[11:8], 1'b0}.
  - U: {s..., In[31:12], 12'b0}. For XLEN=64, bits 63:32 are copies of In[31].
  - J: {s..., In[19:12], In[20], In[30:21], 1'b0}.
  - Illegal select: imm=0 and err=1. For all legal formats err=0.
- FIFO structure:
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - level is incremented on push only, decremented on pop only, and unchanged on simultaneous push and pop.
- Imm_Ext and imm_err show the head entry and stay stable while out_valid && !out_ready.
- When out_valid=0, Imm_Ext and imm_err read 0.
- Entry order is strictly preserved.

## Timing
- Latency: an entry pushed at edge N is presented with out_valid=1 after edge N, i.e. one cycle, when the FIFO was empty.
- Throughput: one entry per cycle with out_ready held at 1.
- Reset (rst=0 sampled at an edge):
  - level=0, pointers=0, out_valid=0, Imm_Ext=0, imm_err=0.
  - Stored entries are discarded, including reset asserted mid-stream.
  - in_ready=1 on the first cycle rst is high.
- Boundary conditions:
  - Full with in_valid=1: no push; the producer holds its inputs.
  - Empty with out_ready=1: no pop; level stays 0.
  - Simultaneous push and pop at level=1: the new entry becomes head after the edge; out_valid stays 1.

## Configuration
- IMM_ZICSR_EN defined:
  - ImmSrc=101 selects the CSR immediate, zero-extended: {0..., In[19:15]}, with err=0.
- IMM_ZICSR_EN undefined:
  - ImmSrc=101 is illegal: imm=0, err=1.
  - No Zicsr logic is synthesised.

## Test plan
- I-type: In=0xFFF00093, ImmSrc=000, XLEN=32 -> one cycle later out_valid=1, Imm_Ext=0xFFFFFFFF, imm_err=0.
- S- and B-type back-to-back with out_ready=1:
  - 0xFE112E23/001 -> 0xFFFFFFFC.
  - then 0xFE000EE3/010 -> 0xFFFFFFFC.
  - Both appear on consecutive cycles.
- U-type width: In=0x800000B7, ImmSrc=011 -> 0x80000000 at XLEN=32 and 0xFFFFFFFF80000000 at XLEN=64.
- Back-pressure, DEPTH=2, out_ready=0:
  - Push I-type 0x00500093 (5), then U-type 0x123450B7 -> level=2, in_ready=0.
  - A third offer is held.
  - Raise out_ready -> outputs 0x00000005, then 0x12345000, then the third entry, in that order.
- Illegal select and macro:
  - ImmSrc=111 -> Imm_Ext=0, imm_err=1.
  - In=0x3400D073, ImmSrc=101 -> 0x00000001 with err=0 when IMM_ZICSR_EN is defined; 0 with err=1 when it is not.
- Reset mid-operation: with level=2, drive rst=0 for one edge -> level=0, out_valid=0, Imm_Ext=0. The next push is the first entry seen.
